// File: rtl/event_indicator_pkg.sv
// Shared types and constants for the event indicator and its channels.
// Optional feature macro: EVENT_INDICATOR_PENDING_EN (per-channel pending-blink queue).
package event_indicator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } ch_state_t;

    localparam int PEND_MAX = 3;
    localparam int PEND_W   = 2;
    localparam int TCNT_W   = 10;
    localparam int NUM_CH   = 5;

endpackage

// File: rtl/indicator_channel.sv
// One LED channel: IDLE -> ON for ON_TICKS ticks -> GAP for GAP_TICKS ticks.
// With EVENT_INDICATOR_PENDING_EN defined, pulses during ON/GAP queue extra blinks (max 3).
module indicator_channel
    import event_indicator_pkg::*;
#(
    parameter int ON_TICKS  = 200,
    parameter int GAP_TICKS = 100
) (
    input  logic clk,
    input  logic buttom_rst,
    input  logic tick,
    input  logic event_pulse,
    output logic led
);

    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);

    ch_state_t         state_reg, state_next;
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic              led_reg, led_next;

`ifdef EVENT_INDICATOR_PENDING_EN
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              pend_full;

    assign pend_full = (pend_reg == PEND_W'(PEND_MAX));
`endif

    always_ff @(posedge clk or negedge buttom_rst) begin
        if (!buttom_rst) begin
            state_reg <= IDLE;
            tcnt_reg  <= '0;
            led_reg   <= 1'b0;
`ifdef EVENT_INDICATOR_PENDING_EN
            pend_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
            led_reg   <= led_next;
`ifdef EVENT_INDICATOR_PENDING_EN
            pend_reg  <= pend_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
`ifdef EVENT_INDICATOR_PENDING_EN
        pend_next  = pend_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (event_pulse) begin
                    state_next = ON;
                    tcnt_next  = '0;
                end
            end

            ON: begin
`ifdef EVENT_INDICATOR_PENDING_EN
                if (event_pulse && !pend_full) begin
                    pend_next = pend_reg + PEND_W'(1);
                end
`endif
                if (tick) begin
                    if (tcnt_reg == ON_LAST) begin
                        state_next = GAP;
                        tcnt_next  = '0;
                    end else begin
                        tcnt_next = tcnt_reg + TCNT_W'(1);
                    end
                end
            end

            GAP: begin
                if (tick && (tcnt_reg == GAP_LAST)) begin
                    tcnt_next = '0;
`ifdef EVENT_INDICATOR_PENDING_EN
                    // A pulse coinciding with consuming a queued blink cancels the decrement
                    if (pend_reg != '0) begin
                        state_next = ON;
                        pend_next  = event_pulse ? pend_reg : pend_reg - PEND_W'(1);
                    end else if (event_pulse) begin
                        state_next = ON;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    // The pulse lands as if the channel were already idle
                    state_next = event_pulse ? ON : IDLE;
`endif
                end else begin
`ifdef EVENT_INDICATOR_PENDING_EN
                    if (event_pulse && !pend_full) begin
                        pend_next = pend_reg + PEND_W'(1);
                    end
`endif
                    if (tick) begin
                        tcnt_next = tcnt_reg + TCNT_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
                tcnt_next  = '0;
            end
        endcase

        led_next = (state_next == ON);
    end

    assign led = led_reg;

endmodule

// File: rtl/event_indicator.sv
// Five-channel button-event LED indicator sharing one free-running tick prescaler.
// Optional feature macro: EVENT_INDICATOR_PENDING_EN (queue up to 3 extra blinks per channel).
module event_indicator
    import event_indicator_pkg::*;
#(
    parameter int PRESCALE_DIV = 100000,
    parameter int ON_TICKS     = 200,
    parameter int GAP_TICKS    = 100
) (
    input  logic clk,
    input  logic buttom_rst,
    input  logic sign_pos_A,
    input  logic sign_pos_S,
    input  logic sign_pos_W,
    input  logic sign_pos_X,
    input  logic sign_pos_D,
    output logic sA,
    output logic sS,
    output logic sW,
    output logic sX,
    output logic sD
);

    localparam int               PS_W    = $clog2(PRESCALE_DIV);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE_DIV - 1);

    logic [PS_W-1:0]   ps_reg;
    logic              tick;
    logic [NUM_CH-1:0] pulses;
    logic [NUM_CH-1:0] leds;

    // Never restarted by events, so blink length jitters by up to one tick
    always_ff @(posedge clk or negedge buttom_rst) begin
        if (!buttom_rst) begin
            ps_reg <= '0;
        end else if (tick) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_reg + PS_W'(1);
        end
    end

    assign tick   = (ps_reg == PS_LAST);
    assign pulses = {sign_pos_D, sign_pos_X, sign_pos_W, sign_pos_S, sign_pos_A};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            indicator_channel #(
                .ON_TICKS  (ON_TICKS),
                .GAP_TICKS (GAP_TICKS)
            ) u_ch (
                .clk         (clk),
                .buttom_rst  (buttom_rst),
                .tick        (tick),
                .event_pulse (pulses[gi]),
                .led         (leds[gi])
            );
        end
    endgenerate

    assign sA = leds[0];
    assign sS = leds[1];
    assign sW = leds[2];
    assign sX = leds[3];
    assign sD = leds[4];

endmodule
